// File: rtl/alu_op_sequencer_if.sv
// Request/response bus between an ALU command producer and alu_op_sequencer.
// The master side issues requests and consumes responses; the slave side is the sequencer.
interface alu_op_sequencer_if #(
  parameter int unsigned W = 4
);
  logic         req_valid;
  logic         req_ready;
  logic [W-1:0] req_a;
  logic [W-1:0] req_b;
  logic [2:0]   req_op;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_result;
  logic         rsp_illegal;

  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_illegal
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_illegal
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Buffers ALU requests in a FIFO, issues them one at a time to the external TotalALU,
// and returns captured results in request order over a valid/ready response channel.
module alu_op_sequencer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  alu_op_sequencer_if.slave    bus,
  output logic [W-1:0]         alu_a,
  output logic [W-1:0]         alu_b,
  output logic [2:0]           alu_signal,
  input  logic [W-1:0]         alu_out,
  output logic                 busy,
  output logic [7:0]           op_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } state_t;

  state_t state_q, state_d;

  logic [W-1:0] mem_a  [DEPTH];
  logic [W-1:0] mem_b  [DEPTH];
  logic [2:0]   mem_op [DEPTH];

  logic [AW:0]  wr_ptr, rd_ptr;
  logic         empty, full;
  logic         push, pop, capture, rsp_done;

  logic [W-1:0] head_a, head_b;
  logic [2:0]   head_op;
  logic         head_illegal;
  logic         illegal_q;

  logic         rsp_valid_q;
  logic [W-1:0] rsp_result_q;
  logic         rsp_illegal_q;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign bus.req_ready   = rst_n && !full;
  assign push            = bus.req_valid && bus.req_ready;

  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_result  = rsp_result_q;
  assign bus.rsp_illegal = rsp_illegal_q;

  assign busy = rst_n && ((state_q != IDLE) || !empty);

  assign head_a       = mem_a[rd_ptr[AW-1:0]];
  assign head_b       = mem_b[rd_ptr[AW-1:0]];
  assign head_op      = mem_op[rd_ptr[AW-1:0]];
  assign head_illegal = !(head_op inside {3'b000, 3'b001, 3'b010, 3'b110, 3'b111});

  always_comb begin
    state_d  = state_q;
    pop      = 1'b0;
    capture  = 1'b0;
    rsp_done = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        capture = 1'b1;
        state_d = RESP;
      end
      RESP: begin
        if (rsp_valid_q && bus.rsp_ready) begin
          rsp_done = 1'b1;
          if (!empty) begin
            pop     = 1'b1;
            state_d = ISSUE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Storage needs no reset: entries are only read once the pointers say they were written.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr[AW-1:0]]  <= bus.req_a;
      mem_b[wr_ptr[AW-1:0]]  <= bus.req_b;
      mem_op[wr_ptr[AW-1:0]] <= bus.req_op;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      alu_a         <= '0;
      alu_b         <= '0;
      alu_signal    <= '0;
      illegal_q     <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_result_q  <= '0;
      rsp_illegal_q <= 1'b0;
      op_count      <= '0;
    end else begin
      state_q <= state_d;
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      // Illegal opcodes are replaced by a zeroed AND so the ALU never sees an undefined code.
      if (pop) begin
        rd_ptr     <= rd_ptr + PTR_ONE;
        alu_a      <= head_illegal ? '0 : head_a;
        alu_b      <= head_illegal ? '0 : head_b;
        alu_signal <= head_illegal ? 3'b000 : head_op;
        illegal_q  <= head_illegal;
      end
      if (capture) begin
        rsp_valid_q   <= 1'b1;
        rsp_result_q  <= illegal_q ? '0 : alu_out;
        rsp_illegal_q <= illegal_q;
      end
      if (rsp_done) begin
        rsp_valid_q <= 1'b0;
        op_count    <= op_count + 8'd1;
      end
    end
  end

endmodule
